// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among several byte requesters.
// Grants one request, strobes the UART, then tracks its busy flag until the frame ends.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned IDX_WIDTH     = 2,
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned BUSY_TIMEOUT  = 8
) (
  input  logic                               UART_TX_ARBITER_CLOCK_50,
  input  logic                               UART_TX_ARBITER_RESET_InLow,
  input  logic [NUM_REQ-1:0]                 UART_TX_ARBITER_req_InHigh,
  input  logic [NUM_REQ*DATAWIDTH_BUS-1:0]   UART_TX_ARBITER_data_In,
  input  logic                               UART_TX_ARBITER_uartBusy_In,
  output logic [NUM_REQ-1:0]                 UART_TX_ARBITER_ack_Out,
  output logic                               UART_TX_ARBITER_newData_Out,
  output logic [DATAWIDTH_BUS-1:0]           UART_TX_ARBITER_data_Out,
  output logic [IDX_WIDTH-1:0]               UART_TX_ARBITER_grantIdx_Out,
  output logic                               UART_TX_ARBITER_busy_Out,
  output logic                               UART_TX_ARBITER_timeoutErr_Out
);

  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

  state_e                     r_state, w_state_d;
  logic [IDX_WIDTH-1:0]       r_ptr, w_ptr_d;
  logic [CntW-1:0]            r_cnt, w_cnt_d;
  logic [NUM_REQ-1:0]         r_ack, w_ack_d;
  logic                       r_new, w_new_d;
  logic [DATAWIDTH_BUS-1:0]   r_data, w_data_d;
  logic [IDX_WIDTH-1:0]       r_grant, w_grant_d;
  logic                       r_busy;
  logic                       r_err, w_err_d;

  logic                       w_found;
  logic [IDX_WIDTH-1:0]       w_winner;
  logic [DATAWIDTH_BUS-1:0]   w_pick_data;
  logic [IDX_WIDTH-1:0]       w_ptr_after;

  // Search from the pointer upward, wrapping, and keep the first requester found.
  always_comb begin : p_pick
    int                   v_pos;
    logic [IDX_WIDTH-1:0] v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_pos    = 0;
    v_idx    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      v_pos = int'(r_ptr) + k;
      if (v_pos >= int'(NUM_REQ)) begin
        v_pos = v_pos - int'(NUM_REQ);
      end
      v_idx = IDX_WIDTH'(v_pos);
      if (!w_found && UART_TX_ARBITER_req_InHigh[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  assign w_pick_data = DATAWIDTH_BUS'(UART_TX_ARBITER_data_In >>
                                      (int'(w_winner) * int'(DATAWIDTH_BUS)));
  assign w_ptr_after = (int'(w_winner) == int'(NUM_REQ) - 1) ? '0 : w_winner + IDX_WIDTH'(1);

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_cnt_d   = r_cnt;
    w_ack_d   = '0;
    w_new_d   = 1'b0;
    w_data_d  = r_data;
    w_grant_d = r_grant;
    w_err_d   = r_err;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_data_d  = w_pick_data;
          w_grant_d = w_winner;
          w_ack_d   = NUM_REQ'(1) << w_winner;
          w_new_d   = 1'b1;
          w_ptr_d   = w_ptr_after;
          w_cnt_d   = '0;
          w_state_d = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (UART_TX_ARBITER_uartBusy_In) begin
          w_state_d = StWaitDone;
        end else if (r_cnt == CntW'(BUSY_TIMEOUT - 1)) begin
          // The byte was already acked, so it is dropped rather than retried.
          w_err_d   = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StWaitDone: begin
        if (!UART_TX_ARBITER_uartBusy_In) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge UART_TX_ARBITER_CLOCK_50) begin
    if (!UART_TX_ARBITER_RESET_InLow) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_new   <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_cnt   <= w_cnt_d;
      r_ack   <= w_ack_d;
      r_new   <= w_new_d;
      r_data  <= w_data_d;
      r_grant <= w_grant_d;
      r_busy  <= (w_state_d != StIdle);
      r_err   <= w_err_d;
    end
  end

  assign UART_TX_ARBITER_ack_Out        = r_ack;
  assign UART_TX_ARBITER_newData_Out    = r_new;
  assign UART_TX_ARBITER_data_Out       = r_data;
  assign UART_TX_ARBITER_grantIdx_Out   = r_grant;
  assign UART_TX_ARBITER_busy_Out       = r_busy;
  assign UART_TX_ARBITER_timeoutErr_Out = r_err;

endmodule
